y_row_reader: RTL and testbench

//  Read-side engine for the Y SRAM, the counterpart to the Y write-back path. It

---
 rtl/y_pkg.sv | 48 ++++
 rtl/y_slot_mux.sv | 26 ++
 rtl/y_row_reader.sv | 212 +++++++++++++++++++++
 tb/tb_y_row_reader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y_pkg.sv
// -----------------------------------------------------------------------------
// y_pkg
// Shared definitions for the Y SRAM read-side engine.
//   MAT_DIM      Y matrix order (entries per row)
//   SLOTS        complex entries packed per 256-bit SRAM word
//   ADDR_W       SRAM word address width
//   Y_SLOT_W     bit pitch of one slot inside a word
//   Y_WORD_W     SRAM word width
//   Y_IDLE_ADDR  address driven when no fetch is in progress
//   y_cplx_t     48-bit complex entry {real[23:0], imag[23:0]}
//   y_state_e    read-engine FSM states
//   y_word_addr  row/col -> SRAM word address
// -----------------------------------------------------------------------------
package y_pkg;

   localparam int MAT_DIM  = 64;
   localparam int SLOTS    = 4;
   localparam int ADDR_W   = 11;
   localparam int Y_SLOT_W = 64;
   localparam int Y_WORD_W = 256;
   localparam int Y_CPLX_W = 48;

   // SLOTS and MAT_DIM/SLOTS are powers of two, so divide/modulo become
   // shifts and bit selects.
   localparam int SLOT_SHIFT = $clog2(SLOTS);
   localparam int ROW_SHIFT  = $clog2(MAT_DIM / SLOTS);

   localparam logic [ADDR_W-1:0] Y_IDLE_ADDR = 11'h7ff;

   typedef logic [Y_CPLX_W-1:0] y_cplx_t;

   typedef enum logic [2:0] {
      Y_IDLE   = 3'd0,
      Y_ISSUE  = 3'd1,
      Y_WAIT   = 3'd2,
      Y_STREAM = 3'd3,
      Y_DONE   = 3'd4
   } y_state_e;

   // word address = row * (MAT_DIM/SLOTS) + col / SLOTS, truncated to ADDR_W.
   function automatic logic [ADDR_W-1:0] y_word_addr(input logic [15:0] row,
                                                     input logic [15:0] col);
      logic [15:0] a;
      a = (row << ROW_SHIFT) + (col >> SLOT_SHIFT);
      return a[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/y_slot_mux.sv
// -----------------------------------------------------------------------------
// y_slot_mux
// Combinational selection of one 48-bit complex entry out of a 256-bit Y word.
// Slot k occupies word[64k+47 : 64k]; the top 16 bits of each slot are unused.
//   word  in   256  SRAM word
//   idx   in   2    slot index (column modulo SLOTS)
//   slot  out  48   selected entry
// -----------------------------------------------------------------------------
module y_slot_mux
   import y_pkg::*;
(
   input  logic [Y_WORD_W-1:0]   word,
   input  logic [SLOT_SHIFT-1:0] idx,
   output y_cplx_t               slot
);

   always_comb begin
      slot = '0;
      for (int k = 0; k < SLOTS; k++) begin
         if (idx == SLOT_SHIFT'(k)) begin
            slot = word[k*Y_SLOT_W +: Y_CPLX_W];
         end
      end
   end

endmodule

// File: rtl/y_row_reader.sv
// -----------------------------------------------------------------------------
// y_row_reader
// Read-side engine for the Y SRAM. Accepts a burst request (row, start column,
// length), fetches the 256-bit words it needs through the arbiter read port and
// streams the 48-bit complex entries one per beat to the Jacobi datapath.
//
// Ports
//   clock       in   1    rising-edge clock
//   reset       in   1    asynchronous, active-low reset
//   req_valid   in   1    burst request valid
//   req_ready   out  1    engine idle and able to take a request
//   req_row     in   16   matrix row
//   req_col     in   16   first column
//   req_len     in   7    entry count 0..MAT_DIM (clamped to the row end)
//   abort       in   1    synchronous cancel of the current burst
//   rd_grant    in   1    arbiter grants the read port this cycle
//   rd_addr     out  11   SRAM word address, 11'h7ff when not fetching
//   rd_data     in   256  SRAM data, valid the cycle after rd_addr
//   out_valid   out  1    entry valid
//   out_ready   in   1    consumer accepts the entry
//   out_data    out  48   {real[23:0], imag[23:0]}
//   out_col     out  16   column of out_data
//   out_last    out  1    final beat of the burst
//   burst_done  out  1    one-cycle pulse when a burst completes or aborts
//   state       out  3    current FSM state (observation only)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised it stays high with its payload unchanged
// until that transfer, except when abort cancels the burst. Valid never
// depends combinationally on ready.
//
// Read protocol: the address is presented in ISSUE; data comes back during
// WAIT. The grant must be held across both cycles, otherwise the bus may be
// carrying another master's data and the word is refetched.
// -----------------------------------------------------------------------------
module y_row_reader
   import y_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [15:0]         req_row,
   input  logic [15:0]         req_col,
   input  logic [6:0]          req_len,
   input  logic                abort,
   input  logic                rd_grant,
   output logic [ADDR_W-1:0]   rd_addr,
   input  logic [Y_WORD_W-1:0] rd_data,
   output logic                out_valid,
   input  logic                out_ready,
   output y_cplx_t             out_data,
   output logic [15:0]         out_col,
   output logic                out_last,
   output logic                burst_done,
   output y_state_e            state
);

   logic [15:0]         row_q;
   logic [15:0]         col_q;
   logic [6:0]          rem_q;
   logic [Y_WORD_W-1:0] word_q;

   logic                req_fire;
   logic                beat_fire;
   logic [15:0]         col_nxt;
   logic [6:0]          rem_nxt;
   logic                req_col_ok;
   logic [6:0]          room;
   logic [6:0]          req_eff_len;

   logic [Y_WORD_W-1:0]   mux_word;
   logic [SLOT_SHIFT-1:0] mux_idx;
   y_cplx_t               mux_slot;

   assign req_fire  = req_valid & req_ready;
   assign beat_fire = out_valid & out_ready;
   assign col_nxt   = col_q + 16'd1;
   assign rem_nxt   = rem_q - 7'd1;

   // Room left in the row; only meaningful when the start column is in range,
   // in which case it is 1..MAT_DIM and fits in 7 bits.
   assign req_col_ok  = (req_col < 16'(MAT_DIM));
   assign room        = 7'(MAT_DIM) - req_col[6:0];
   assign req_eff_len = (req_col_ok && (req_len > room)) ? room : req_len;

   // out_data is registered, so the mux looks one step ahead: in WAIT it picks
   // the first entry straight off the bus, in STREAM it picks the entry for
   // the column that follows the beat being accepted.
   always_comb begin
      mux_word = word_q;
      mux_idx  = col_nxt[SLOT_SHIFT-1:0];
      if (state == Y_WAIT) begin
         mux_word = rd_data;
         mux_idx  = col_q[SLOT_SHIFT-1:0];
      end
   end

   y_slot_mux u_slot_mux (
      .word (mux_word),
      .idx  (mux_idx),
      .slot (mux_slot)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= Y_IDLE;
         req_ready  <= 1'b0;
         rd_addr    <= Y_IDLE_ADDR;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_col    <= '0;
         out_last   <= 1'b0;
         burst_done <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         rem_q      <= '0;
         word_q     <= '0;
      end else begin
         burst_done <= 1'b0;
         // Abort wins in every busy state. DONE is already on its way back to
         // IDLE, so a held abort must not keep re-entering it.
         if (abort && (state != Y_IDLE) && (state != Y_DONE)) begin
            state      <= Y_DONE;
            req_ready  <= 1'b0;
            rd_addr    <= Y_IDLE_ADDR;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            burst_done <= 1'b1;
         end else begin
            case (state)
               Y_IDLE: begin
                  req_ready <= 1'b1;
                  if (req_fire) begin
                     req_ready <= 1'b0;
                     row_q     <= req_row;
                     col_q     <= req_col;
                     rem_q     <= req_eff_len;
                     if (!req_col_ok || (req_eff_len == 7'd0)) begin
                        // Nothing to stream: report completion with no beats.
                        state      <= Y_DONE;
                        burst_done <= 1'b1;
                     end else begin
                        state   <= Y_ISSUE;
                        rd_addr <= y_word_addr(req_row, req_col);
                     end
                  end
               end

               Y_ISSUE: begin
                  if (rd_grant) begin
                     state   <= Y_WAIT;
                     rd_addr <= Y_IDLE_ADDR;
                  end
               end

               Y_WAIT: begin
                  if (rd_grant) begin
                     word_q    <= rd_data;
                     state     <= Y_STREAM;
                     out_valid <= 1'b1;
                     out_data  <= mux_slot;
                     out_col   <= col_q;
                     out_last  <= (rem_q == 7'd1);
                  end else begin
                     // Grant lost while the data was in flight: refetch.
                     state   <= Y_ISSUE;
                     rd_addr <= y_word_addr(row_q, col_q);
                  end
               end

               Y_STREAM: begin
                  if (beat_fire) begin
                     col_q <= col_nxt;
                     rem_q <= rem_nxt;
                     if (rem_q == 7'd1) begin
                        state      <= Y_DONE;
                        out_valid  <= 1'b0;
                        out_last   <= 1'b0;
                        burst_done <= 1'b1;
                     end else if (col_nxt[SLOT_SHIFT-1:0] == '0) begin
                        // Next column lives in the following SRAM word.
                        state     <= Y_ISSUE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        rd_addr   <= y_word_addr(row_q, col_nxt);
                     end else begin
                        out_data <= mux_slot;
                        out_col  <= col_nxt;
                        out_last <= (rem_nxt == 7'd1);
                     end
                  end
               end

               Y_DONE: begin
                  state     <= Y_IDLE;
                  req_ready <= 1'b1;
               end

               default: begin
                  state     <= Y_IDLE;
                  req_ready <= 1'b0;
                  rd_addr   <= Y_IDLE_ADDR;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_y_row_reader.sv
`timescale 1ns/1ps
module tb_y_row_reader;
   import y_pkg::*;

   // ---------------- clock / reset ----------------
   logic         clock = 1'b0;
   logic         reset = 1'b0;
   always #5 clock = ~clock;

   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [15:0]  req_row = '0;
   logic [15:0]  req_col = '0;
   logic [6:0]   req_len = '0;
   logic         abort = 1'b0;
   logic         rd_grant = 1'b0;
   logic [10:0]  rd_addr;
   logic [255:0] rd_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [47:0]  out_data;
   logic [15:0]  out_col;
   logic         out_last;
   logic         burst_done;
   y_state_e     state;

   int tests_run = 0;
   int tests_failed = 0;

   y_row_reader dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_row    (req_row),
      .req_col    (req_col),
      .req_len    (req_len),
      .abort      (abort),
      .rd_grant   (rd_grant),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_col    (out_col),
      .out_last   (out_last),
      .burst_done (burst_done),
      .state      (state)
   );

   // ---------------- SRAM / arbiter model ----------------
   function automatic logic [47:0] elem(input int addr, input int k);
      logic [23:0] v;
      v = 24'(addr * 4 + k) + 24'h010000;
      return {v, ~v};
   endfunction

   function automatic logic [255:0] mem_word(input int addr);
      logic [255:0] w;
      for (int k = 0; k < 4; k++) w[k*64 +: 64] = {16'hCAFE, elem(addr, k)};
      return w;
   endfunction

   // Expected entry at (row, col) from the word-address formula.
   function automatic logic [47:0] exp_elem(input int row, input int col);
      return elem(row * 16 + col / 4, col % 4);
   endfunction

   logic [10:0] data_addr = '0;
   logic        data_vld = 1'b0;
   always @(posedge clock) begin
      data_vld  <= rd_grant && (rd_addr != 11'h7ff);
      data_addr <= rd_addr;
   end
   // Without the grant the bus carries someone else's data.
   assign rd_data = (rd_grant && data_vld) ? mem_word(int'(data_addr)) : {8{32'hDEADBEEF}};

   // ---------------- monitor ----------------
   int           cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [15:0]  b_col[$];
   logic [47:0]  b_data[$];
   logic         b_last[$];
   int           b_cyc[$];
   logic [10:0]  a_log[$];
   int           done_cnt = 0;
   int           done_cyc = 0;

   always @(negedge clock) begin
      if (reset === 1'b1) begin
         if (out_valid && out_ready) begin
            b_col.push_back(out_col);
            b_data.push_back(out_data);
            b_last.push_back(out_last);
            b_cyc.push_back(cyc);
         end
         if (rd_addr != 11'h7ff) a_log.push_back(rd_addr);
         if (burst_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Returns k = cycle in which the request handshake happens.
   task automatic issue_req(input int row, input int col, input int len, output int k);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin step(); n++; end
      if (req_ready !== 1'b1) begin
         tests_run++; tests_failed++;
         $display("FAIL req_ready_timeout: req_ready=%b, required 1", req_ready);
      end
      req_valid = 1'b1;
      req_row = 16'(row);
      req_col = 16'(col);
      req_len = 7'(len);
      k = cyc;
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int n;
      n = 0;
      while (done_cnt == d0 && n < budget) begin step(); n++; end
      if (done_cnt == d0) begin
         tests_run++; tests_failed++;
         $display("FAIL burst_done_timeout: no burst_done within %0d cycles", budget);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      step(); step(); step();
      tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_req_ready: got %b, expected 0", req_ready); end
      tests_run++; if (rd_addr !== 11'h7ff) begin tests_failed++; $display("FAIL rst_rd_addr: got %h, expected 7ff", rd_addr); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
      tests_run++; if (out_data !== 48'd0) begin tests_failed++; $display("FAIL rst_out_data: got %h, expected 0", out_data); end
      tests_run++; if (out_col !== 16'd0) begin tests_failed++; $display("FAIL rst_out_col: got %0d, expected 0", out_col); end
      tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL rst_out_last: got %b, expected 0", out_last); end
      tests_run++; if (burst_done !== 1'b0) begin tests_failed++; $display("FAIL rst_burst_done: got %b, expected 0", burst_done); end
      tests_run++; if (state !== Y_IDLE) begin tests_failed++; $display("FAIL rst_state: got %0d, expected IDLE", state); end
      reset = 1'b1;
      step(); step();
      tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %b, expected 1", req_ready); end
   endtask

   task automatic test_single_word();
      int k, b0, a0, d0;
      b0 = b_col.size(); a0 = a_log.size(); d0 = done_cnt;
      rd_grant = 1'b1; out_ready = 1'b1;
      issue_req(3, 0, 4, k);
      wait_done(d0, 40);
      tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL t1_req_ready_after_done: got %b, expected 1", req_ready); end
      tests_run++; if (a_log.size() - a0 !== 1) begin tests_failed++; $display("FAIL t1_addr_count: got %0d, expected 1", a_log.size() - a0); end
      if (a_log.size() > a0) begin
         tests_run++; if (a_log[a0] !== 11'd48) begin tests_failed++; $display("FAIL t1_addr: got %0d, expected 48", a_log[a0]); end
      end
      tests_run++; if (b_col.size() - b0 !== 4) begin tests_failed++; $display("FAIL t1_beats: got %0d, expected 4", b_col.size() - b0); end
      for (int i = 0; i < 4 && b0 + i < b_col.size(); i++) begin
         tests_run++; if (b_col[b0+i] !== 16'(i)) begin tests_failed++; $display("FAIL t1_col[%0d]: got %0d, expected %0d", i, b_col[b0+i], i); end
         tests_run++; if (b_data[b0+i] !== exp_elem(3, i)) begin tests_failed++; $display("FAIL t1_data[%0d]: got %h, expected %h", i, b_data[b0+i], exp_elem(3, i)); end
         tests_run++; if (b_last[b0+i] !== (i == 3)) begin tests_failed++; $display("FAIL t1_last[%0d]: got %b, expected %b", i, b_last[b0+i], (i == 3)); end
         tests_run++; if (b_cyc[b0+i] !== k + 3 + i) begin tests_failed++; $display("FAIL t1_cycle[%0d]: got %0d, expected %0d", i, b_cyc[b0+i], k + 3 + i); end
      end
      tests_run++; if (done_cyc !== k + 7) begin tests_failed++; $display("FAIL t1_done_cycle: got %0d, expected %0d", done_cyc, k + 7); end
      tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL t1_done_pulses: got %0d, expected 1", done_cnt - d0); end
   endtask

   task automatic test_cross_word();
      int k, b0, a0, d0;
      int off[5];
      off = '{3, 4, 7, 8, 9};
      b0 = b_col.size(); a0 = a_log.size(); d0 = done_cnt;
      issue_req(0, 2, 5, k);
      wait_done(d0, 40);
      tests_run++; if (a_log.size() - a0 !== 2) begin tests_failed++; $display("FAIL t2_addr_count: got %0d, expected 2", a_log.size() - a0); end
      for (int i = 0; i < 2 && a0 + i < a_log.size(); i++) begin
         tests_run++; if (a_log[a0+i] !== 11'(i)) begin tests_failed++; $display("FAIL t2_addr[%0d]: got %0d, expected %0d", i, a_log[a0+i], i); end
      end
      tests_run++; if (b_col.size() - b0 !== 5) begin tests_failed++; $display("FAIL t2_beats: got %0d, expected 5", b_col.size() - b0); end
      for (int i = 0; i < 5 && b0 + i < b_col.size(); i++) begin
         tests_run++; if (b_col[b0+i] !== 16'(2 + i)) begin tests_failed++; $display("FAIL t2_col[%0d]: got %0d, expected %0d", i, b_col[b0+i], 2 + i); end
         tests_run++; if (b_data[b0+i] !== exp_elem(0, 2 + i)) begin tests_failed++; $display("FAIL t2_data[%0d]: got %h, expected %h", i, b_data[b0+i], exp_elem(0, 2 + i)); end
         tests_run++; if (b_last[b0+i] !== (i == 4)) begin tests_failed++; $display("FAIL t2_last[%0d]: got %b, expected %b", i, b_last[b0+i], (i == 4)); end
         tests_run++; if (b_cyc[b0+i] !== k + off[i]) begin tests_failed++; $display("FAIL t2_cycle[%0d]: got %0d, expected %0d", i, b_cyc[b0+i], k + off[i]); end
      end
      tests_run++; if (done_cyc !== k + 10) begin tests_failed++; $display("FAIL t2_done_cycle: got %0d, expected %0d", done_cyc, k + 10); end
   endtask

   task automatic test_clamp();
      int k, b0, a0, d0;
      b0 = b_col.size(); a0 = a_log.size(); d0 = done_cnt;
      issue_req(5, 60, 10, k);
      wait_done(d0, 40);
      tests_run++; if (b_col.size() - b0 !== 4) begin tests_failed++; $display("FAIL t3_clamp_beats: got %0d, expected 4", b_col.size() - b0); end
      for (int i = 0; i < 4 && b0 + i < b_col.size(); i++) begin
         tests_run++; if (b_col[b0+i] !== 16'(60 + i)) begin tests_failed++; $display("FAIL t3_col[%0d]: got %0d, expected %0d", i, b_col[b0+i], 60 + i); end
         tests_run++; if (b_data[b0+i] !== exp_elem(5, 60 + i)) begin tests_failed++; $display("FAIL t3_data[%0d]: got %h, expected %h", i, b_data[b0+i], exp_elem(5, 60 + i)); end
         tests_run++; if (b_last[b0+i] !== (i == 3)) begin tests_failed++; $display("FAIL t3_last[%0d]: got %b, expected %b", i, b_last[b0+i], (i == 3)); end
      end
      tests_run++; if (a_log.size() - a0 !== 1) begin tests_failed++; $display("FAIL t3_addr_count: got %0d, expected 1", a_log.size() - a0); end
      if (a_log.size() > a0) begin
         tests_run++; if (a_log[a0] !== 11'd95) begin tests_failed++; $display("FAIL t3_addr: got %0d, expected 95", a_log[a0]); end
      end
      // zero length: completion pulse, no beats, no fetch
      b0 = b_col.size(); a0 = a_log.size(); d0 = done_cnt;
      issue_req(1, 0, 0, k);
      wait_done(d0, 20);
      tests_run++; if (done_cyc !== k + 1) begin tests_failed++; $display("FAIL t3_len0_done_cycle: got %0d, expected %0d", done_cyc, k + 1); end
      tests_run++; if (b_col.size() - b0 !== 0) begin tests_failed++; $display("FAIL t3_len0_beats: got %0d, expected 0", b_col.size() - b0); end
      tests_run++; if (a_log.size() - a0 !== 0) begin tests_failed++; $display("FAIL t3_len0_fetches: got %0d, expected 0", a_log.size() - a0); end
      // start column past the row end
      b0 = b_col.size(); a0 = a_log.size(); d0 = done_cnt;
      issue_req(1, 64, 5, k);
      wait_done(d0, 20);
      tests_run++; if (b_col.size() - b0 !== 0) begin tests_failed++; $display("FAIL t3_col64_beats: got %0d, expected 0", b_col.size() - b0); end
      tests_run++; if (a_log.size() - a0 !== 0) begin tests_failed++; $display("FAIL t3_col64_fetches: got %0d, expected 0", a_log.size() - a0); end
   endtask

   task automatic test_stall();
      int k, b0, d0, n;
      logic [15:0] pat;
      logic        prev_stall;
      logic [47:0] p_data;
      logic [15:0] p_col;
      logic        p_last;
      pat = 16'b0110_1001_1101_0011;
      b0 = b_col.size(); d0 = done_cnt;
      prev_stall = 1'b0; p_data = '0; p_col = '0; p_last = 1'b0;
      out_ready = 1'b0;
      issue_req(2, 0, 8, k);
      n = 0;
      while (done_cnt == d0 && n < 80) begin
         if (prev_stall) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== p_data || out_col !== p_col || out_last !== p_last) begin
               tests_failed++;
               $display("FAIL t4_stall_hold: got v=%b col=%0d data=%h last=%b, expected v=1 col=%0d data=%h last=%b",
                        out_valid, out_col, out_data, out_last, p_col, p_data, p_last);
            end
         end
         out_ready = pat[n % 16];
         prev_stall = out_valid && !out_ready;
         p_data = out_data; p_col = out_col; p_last = out_last;
         step();
         n++;
      end
      out_ready = 1'b1;
      if (done_cnt == d0) begin
         tests_run++; tests_failed++;
         $display("FAIL t4_timeout: burst did not complete in 80 cycles");
      end
      tests_run++; if (b_col.size() - b0 !== 8) begin tests_failed++; $display("FAIL t4_beats: got %0d, expected 8", b_col.size() - b0); end
      for (int i = 0; i < 8 && b0 + i < b_col.size(); i++) begin
         tests_run++; if (b_col[b0+i] !== 16'(i)) begin tests_failed++; $display("FAIL t4_col[%0d]: got %0d, expected %0d", i, b_col[b0+i], i); end
         tests_run++; if (b_data[b0+i] !== exp_elem(2, i)) begin tests_failed++; $display("FAIL t4_data[%0d]: got %h, expected %h", i, b_data[b0+i], exp_elem(2, i)); end
         tests_run++; if (b_last[b0+i] !== (i == 7)) begin tests_failed++; $display("FAIL t4_last[%0d]: got %b, expected %b", i, b_last[b0+i], (i == 7)); end
      end
   endtask

   task automatic test_grant_drop();
      int k, b0, a0, d0;
      b0 = b_col.size(); a0 = a_log.size(); d0 = done_cnt;
      rd_grant = 1'b1; out_ready = 1'b1;
      issue_req(7, 4, 3, k);          // now in cycle k+1 (ISSUE)
      step();                         // k+2: WAIT
      tests_run++; if (state !== Y_WAIT) begin tests_failed++; $display("FAIL t5_wait_state: got %0d, expected WAIT", state); end
      rd_grant = 1'b0;
      step();                         // k+3: back to ISSUE
      tests_run++; if (state !== Y_ISSUE) begin tests_failed++; $display("FAIL t5_reissue_state: got %0d, expected ISSUE", state); end
      tests_run++; if (rd_addr !== 11'd113) begin tests_failed++; $display("FAIL t5_reissue_addr: got %0d, expected 113", rd_addr); end
      step();                         // k+4: no grant, ISSUE holds
      tests_run++; if (state !== Y_ISSUE || rd_addr !== 11'd113) begin tests_failed++; $display("FAIL t5_issue_hold: got state=%0d addr=%0d, expected ISSUE/113", state, rd_addr); end
      rd_grant = 1'b1;                // WAIT at k+5, STREAM at k+6
      wait_done(d0, 40);
      tests_run++; if (a_log.size() - a0 !== 3) begin tests_failed++; $display("FAIL t5_addr_count: got %0d, expected 3", a_log.size() - a0); end
      tests_run++; if (b_col.size() - b0 !== 3) begin tests_failed++; $display("FAIL t5_beats: got %0d, expected 3", b_col.size() - b0); end
      for (int i = 0; i < 3 && b0 + i < b_col.size(); i++) begin
         tests_run++; if (b_data[b0+i] !== elem(113, i)) begin tests_failed++; $display("FAIL t5_data[%0d]: got %h, expected %h", i, b_data[b0+i], elem(113, i)); end
         tests_run++; if (b_col[b0+i] !== 16'(4 + i)) begin tests_failed++; $display("FAIL t5_col[%0d]: got %0d, expected %0d", i, b_col[b0+i], 4 + i); end
      end
      if (b_cyc.size() > b0) begin
         tests_run++; if (b_cyc[b0] !== k + 6) begin tests_failed++; $display("FAIL t5_first_beat_cycle: got %0d, expected %0d", b_cyc[b0], k + 6); end
      end
   endtask

   task automatic test_abort();
      int k, b0, d0;
      logic saw_last;
      b0 = b_col.size(); d0 = done_cnt;
      rd_grant = 1'b1; out_ready = 1'b1;
      issue_req(4, 0, 8, k);          // k+1
      step(); step(); step();         // k+4: second beat on the bus
      abort = 1'b1;
      step();                         // k+5
      abort = 1'b0;
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL t6_abort_valid: got %b, expected 0", out_valid); end
      tests_run++; if (burst_done !== 1'b1) begin tests_failed++; $display("FAIL t6_abort_done: got %b, expected 1", burst_done); end
      tests_run++; if (state !== Y_DONE) begin tests_failed++; $display("FAIL t6_abort_state: got %0d, expected DONE", state); end
      tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL t6_abort_ready_early: got %b, expected 0", req_ready); end
      step();                         // k+6
      tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL t6_abort_ready: got %b, expected 1", req_ready); end
      tests_run++; if (burst_done !== 1'b0) begin tests_failed++; $display("FAIL t6_done_width: got %b, expected 0", burst_done); end
      tests_run++; if (b_col.size() - b0 !== 2) begin tests_failed++; $display("FAIL t6_beats: got %0d, expected 2", b_col.size() - b0); end
      saw_last = 1'b0;
      for (int i = b0; i < b_last.size(); i++) saw_last |= b_last[i];
      tests_run++; if (saw_last !== 1'b0) begin tests_failed++; $display("FAIL t6_no_last: got %b, expected 0", saw_last); end
      tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL t6_done_pulses: got %0d, expected 1", done_cnt - d0); end
      // abort while idle does nothing
      d0 = done_cnt;
      abort = 1'b1;
      step(); step();
      abort = 1'b0;
      tests_run++; if (state !== Y_IDLE || req_ready !== 1'b1) begin tests_failed++; $display("FAIL t6_idle_abort: got state=%0d ready=%b, expected IDLE/1", state, req_ready); end
      tests_run++; if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL t6_idle_abort_done: got %0d, expected 0", done_cnt - d0); end
   endtask

   task automatic test_reset_mid();
      int k;
      rd_grant = 1'b1; out_ready = 1'b1;
      issue_req(1, 0, 8, k);          // k+1
      step(); step();                 // k+3: streaming
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL t7_pre_reset_valid: got %b, expected 1", out_valid); end
      #2;
      reset = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b0 || out_last !== 1'b0 || burst_done !== 1'b0) begin tests_failed++; $display("FAIL t7_reset_flags: got v=%b last=%b done=%b, expected 0/0/0", out_valid, out_last, burst_done); end
      tests_run++; if (rd_addr !== 11'h7ff) begin tests_failed++; $display("FAIL t7_reset_addr: got %h, expected 7ff", rd_addr); end
      tests_run++; if (out_data !== 48'd0 || out_col !== 16'd0) begin tests_failed++; $display("FAIL t7_reset_data: got data=%h col=%0d, expected 0/0", out_data, out_col); end
      tests_run++; if (state !== Y_IDLE || req_ready !== 1'b0) begin tests_failed++; $display("FAIL t7_reset_state: got state=%0d ready=%b, expected IDLE/0", state, req_ready); end
      step(); step();
      reset = 1'b1;
      step(); step();
      tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL t7_recover_ready: got %b, expected 1", req_ready); end
   endtask

   task automatic test_back_to_back();
      int k, b0, d0;
      b0 = b_col.size();
      rd_grant = 1'b1; out_ready = 1'b1;
      d0 = done_cnt;
      issue_req(6, 8, 2, k);
      wait_done(d0, 40);
      d0 = done_cnt;
      issue_req(6, 10, 2, k);
      wait_done(d0, 40);
      tests_run++; if (b_col.size() - b0 !== 4) begin tests_failed++; $display("FAIL t8_beats: got %0d, expected 4", b_col.size() - b0); end
      for (int i = 0; i < 4 && b0 + i < b_col.size(); i++) begin
         tests_run++; if (b_col[b0+i] !== 16'(8 + i)) begin tests_failed++; $display("FAIL t8_col[%0d]: got %0d, expected %0d", i, b_col[b0+i], 8 + i); end
         tests_run++; if (b_data[b0+i] !== exp_elem(6, 8 + i)) begin tests_failed++; $display("FAIL t8_data[%0d]: got %h, expected %h", i, b_data[b0+i], exp_elem(6, 8 + i)); end
         tests_run++; if (b_last[b0+i] !== (i == 1 || i == 3)) begin tests_failed++; $display("FAIL t8_last[%0d]: got %b, expected %b", i, b_last[b0+i], (i == 1 || i == 3)); end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_single_word();
      test_cross_word();
      test_clamp();
      test_stall();
      test_grant_drop();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      step(); step();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 200000 ns");
      $fatal(1);
   end

endmodule
